// File: rtl/osc_spike_scheduler.sv
// osc_spike_scheduler
// Captures per-neuron spike events into a pending vector and serialises them
// round-robin onto one valid/ready event port, with a fixed settle holdoff
// after every accepted event. Events that hit an already-pending source are
// counted as lost in a saturating 8-bit counter.
module osc_spike_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDW       = $clog2(N_NEURONS),
    parameter int GAP_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 ev_ready,
    output logic                 ev_valid,
    output logic [IDW-1:0]       ev_id,
    output logic [N_NEURONS-1:0] pending,
    output logic [7:0]           drop_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Holdoff counter must hold GAP_CYC-1; keep at least one bit.
    localparam int HCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N_NEURONS - 1);

    state_t               state_reg, state_next;
    logic                 ev_valid_next;
    logic [IDW-1:0]       ev_id_next;
    logic [IDW-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [HCW-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [N_NEURONS-1:0] pending_next;
    logic [7:0]           drop_cnt_next;

    logic                 win_found;
    logic [IDW-1:0]       win_id;
    logic                 grant;
    logic [N_NEURONS-1:0] granted_bit;
    logic [N_NEURONS-1:0] lost;
    logic [4:0]           loss_cnt;
    logic [9:0]           drop_sum;

    // Round-robin search: first pending source at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_NEURONS) begin
                idx = idx - N_NEURONS;
            end
            if (!win_found && pending[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    assign grant = (state_reg == IDLE) && ena && win_found;

    // Per-source capture: a spike on a source being granted this edge re-arms
    // it; a spike on a source still pending is lost.
    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_capture
            assign granted_bit[gi]  = grant && (win_id == IDW'(gi));
            assign lost[gi]         = spike_in[gi] && pending[gi] && !granted_bit[gi];
            assign pending_next[gi] = spike_in[gi] || (pending[gi] && !granted_bit[gi]);
        end
    endgenerate

    // Number of events lost this edge, added to the counter with saturation.
    always_comb begin
        loss_cnt = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            loss_cnt = loss_cnt + 5'(lost[k]);
        end
        drop_sum      = {2'b00, drop_cnt} + {5'b00000, loss_cnt};
        drop_cnt_next = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_next    = state_reg;
        ev_valid_next = ev_valid;
        ev_id_next    = ev_id;
        rr_ptr_next   = rr_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    ev_id_next    = win_id;
                    ev_valid_next = 1'b1;
                    rr_ptr_next   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    state_next    = OFFER;
                end
            end
            OFFER: begin
                // ena is deliberately ignored here: an offered event is never withdrawn.
                if (ev_ready) begin
                    ev_valid_next = 1'b0;
                    if (GAP_CYC > 0) begin
                        hold_cnt_next = HOLD_LOAD;
                        state_next    = HOLD;
                    end else begin
                        state_next    = IDLE;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                end
            end
            default: begin
                ev_valid_next = 1'b0;
                state_next    = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any offered or pending event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ev_valid     <= 1'b0;
            ev_id        <= '0;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
            pending      <= '0;
            drop_cnt     <= '0;
        end else begin
            state_reg    <= state_next;
            ev_valid     <= ev_valid_next;
            ev_id        <= ev_id_next;
            rr_ptr_reg   <= rr_ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            pending      <= pending_next;
            drop_cnt     <= drop_cnt_next;
        end
    end

    assign busy = (|pending) || ev_valid || (state_reg != IDLE);

endmodule

// File: tb/tb_osc_spike_scheduler.sv
// Directed testbench for osc_spike_scheduler (N=4, GAP_CYC=2).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_osc_spike_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] spike_in = 4'b0000;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic [3:0] pending;
    logic [7:0] drop_cnt;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    osc_spike_scheduler #(
        .N_NEURONS(4),
        .IDW      (2),
        .GAP_CYC  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .spike_in(spike_in),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_id   (ev_id),
        .pending (pending),
        .drop_cnt(drop_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        spike_in = 4'b0000;
        ena      = 1'b1;
        ev_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Tick until ev_valid is seen (at most budget cycles); reports one line per grant.
    task automatic wait_grant(input string tag, input int budget, output logic [1:0] id, output int at);
        id = 2'b00;
        at = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (ev_valid) begin
                id = ev_id;
                at = cyc;
                $display("[%0d] %s grant id=%0d drop_cnt=%0d", cyc, tag, ev_id, drop_cnt);
                return;
            end
        end
        check({tag, "_timeout"}, 32'(ev_valid), 32'd1);
    endtask

    initial begin
        logic [1:0] id;
        int at;
        int prev;

        // Reset state
        do_reset();
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_id", 32'(ev_id), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_busy", 32'(busy), 0);

        // 1: single spike, two-edge latency, holdoff then idle
        spike_in = 4'b0001;
        ev_ready = 1'b1;
        tick();
        spike_in = 4'b0000;
        check("t1_pend_e0", 32'(pending), 1);
        check("t1_valid_e0", 32'(ev_valid), 0);
        tick();
        check("t1_valid_e1", 32'(ev_valid), 1);
        check("t1_id_e1", 32'(ev_id), 0);
        check("t1_pend_e1", 32'(pending), 0);
        tick();
        check("t1_valid_e2", 32'(ev_valid), 0);
        check("t1_busy_e2", 32'(busy), 1);
        tick();
        check("t1_busy_e3", 32'(busy), 1);
        tick();
        check("t1_busy_e4", 32'(busy), 0);
        $display("[%0d] t1 single spike done", cyc);

        // 2: four simultaneous spikes, grants 0..3 spaced 4 cycles
        do_reset();
        ev_ready = 1'b1;
        spike_in = 4'b1111;
        tick();
        spike_in = 4'b0000;
        check("t2_pend", 32'(pending), 15);
        prev = cyc;
        for (int g = 0; g < 4; g++) begin
            wait_grant("t2", 20, id, at);
            check($sformatf("t2_id%0d", g), 32'(id), 32'(g));
            check($sformatf("t2_gap%0d", g), 32'(at - prev), (g == 0) ? 32'd1 : 32'd4);
            prev = at;
        end
        check("t2_drop", 32'(drop_cnt), 0);

        // 3: offer held while not ready; second re-hit of pending source is lost
        do_reset();
        spike_in = 4'b0100;
        tick();
        spike_in = 4'b0000;
        tick();
        check("t3_valid", 32'(ev_valid), 1);
        check("t3_id", 32'(ev_id), 2);
        for (int i = 0; i < 10; i++) begin
            spike_in = (i == 2 || i == 5) ? 4'b0100 : 4'b0000;
            tick();
            check($sformatf("t3_hold_valid%0d", i), 32'(ev_valid), 1);
            check($sformatf("t3_hold_id%0d", i), 32'(ev_id), 2);
        end
        spike_in = 4'b0000;
        check("t3_pend", 32'(pending), 4);
        check("t3_drop", 32'(drop_cnt), 1);
        $display("[%0d] t3 stalled offer done drop_cnt=%0d", cyc, drop_cnt);

        // 4: held spikes 0011 alternate grants; losses accumulate and saturate
        do_reset();
        ev_ready = 1'b1;
        spike_in = 4'b0011;
        tick();
        check("t4_pend_e0", 32'(pending), 3);
        check("t4_drop_e0", 32'(drop_cnt), 0);
        tick();
        check("t4_id0", 32'(ev_id), 0);
        check("t4_valid_e1", 32'(ev_valid), 1);
        check("t4_drop_e1", 32'(drop_cnt), 1);
        tick();
        check("t4_drop_e2", 32'(drop_cnt), 3);
        wait_grant("t4", 20, id, at);
        check("t4_id1", 32'(id), 1);
        wait_grant("t4", 20, id, at);
        check("t4_id2", 32'(id), 0);
        wait_grant("t4", 20, id, at);
        check("t4_id3", 32'(id), 1);
        repeat (200) tick();
        check("t4_drop_sat", 32'(drop_cnt), 255);
        repeat (5) tick();
        check("t4_drop_sat_hold", 32'(drop_cnt), 255);
        spike_in = 4'b0000;

        // 5: ena low accumulates without granting, then grants resume in order
        do_reset();
        ev_ready = 1'b1;
        ena = 1'b0;
        spike_in = 4'b0101;
        tick();
        spike_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_novalid%0d", i), 32'(ev_valid), 0);
        end
        check("t5_pend", 32'(pending), 5);
        ena = 1'b1;
        wait_grant("t5", 10, id, at);
        check("t5_id0", 32'(id), 0);
        wait_grant("t5", 10, id, at);
        check("t5_id1", 32'(id), 2);

        // 6: asynchronous reset during an offer clears everything at once
        do_reset();
        spike_in = 4'b1000;
        tick();
        spike_in = 4'b0000;
        tick();
        check("t6_valid", 32'(ev_valid), 1);
        check("t6_id", 32'(ev_id), 3);
        spike_in = 4'b0001;
        tick();
        spike_in = 4'b0000;
        check("t6_pend_pre", 32'(pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(ev_valid), 0);
        check("t6_rst_id", 32'(ev_id), 0);
        check("t6_rst_pend", 32'(pending), 0);
        check("t6_rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_post_valid%0d", i), 32'(ev_valid), 0);
            check($sformatf("t6_post_busy%0d", i), 32'(busy), 0);
        end
        $display("[%0d] t6 async reset done", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
